// File: rtl/mux_sync_rx_multi_if.sv
// mux_sync_rx_multi_if: request/data/handshake bundle between a write-domain source and the receiver
interface mux_sync_rx_multi_if #(
   parameter int NUM_CH     = 4,
   parameter int DATA_WIDTH = 12
);
   logic [NUM_CH-1:0]            wr_req;
   logic [NUM_CH*DATA_WIDTH-1:0] wr_data;
   logic [NUM_CH-1:0]            rd_pop;
   logic [NUM_CH-1:0]            ovf_clr;
   logic [NUM_CH*DATA_WIDTH-1:0] rd_data;
   logic [NUM_CH-1:0]            rd_valid;
   logic [NUM_CH-1:0]            rd_ack;
   logic [NUM_CH-1:0]            rd_ovf;
   logic                         rd_any_valid;
   modport master (
      output wr_req, wr_data, rd_pop, ovf_clr,
      input  rd_data, rd_valid, rd_ack, rd_ovf, rd_any_valid
   );
   modport slave (
      input  wr_req, wr_data, rd_pop, ovf_clr,
      output rd_data, rd_valid, rd_ack, rd_ovf, rd_any_valid
   );
endinterface

// File: rtl/mux_sync_rx_multi.sv
// mux_sync_rx_multi: multi-channel mux-synchroniser receiver with valid/pop, ack return and sticky overrun
module mux_sync_rx_multi #(
   parameter int NUM_CH      = 4,
   parameter int DATA_WIDTH  = 12,
   parameter int SYNC_STAGES = 2,
   parameter int TOGGLE_MODE = 0
) (
   input logic                rd_clk,
   input logic                rd_reset,
   mux_sync_rx_multi_if.slave bus
);
   logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q, sync_d;
   logic [NUM_CH-1:0]                  req_last_q, req_last_d;
   logic [NUM_CH-1:0]                  valid_q, valid_d;
   logic [NUM_CH-1:0]                  ovf_q, ovf_d;
   logic [NUM_CH-1:0]                  sync_out, evt;
   logic [NUM_CH*DATA_WIDTH-1:0]       data_q, data_d;
   logic                               any_valid_q, any_valid_d;
   generate
      if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
         $error("SYNC_STAGES must be in 2..4");
      end
   endgenerate
   always_comb begin
      sync_d      = {sync_q[SYNC_STAGES-2:0], bus.wr_req};
      sync_out    = sync_q[SYNC_STAGES-1];
      req_last_d  = sync_out;
      evt         = (TOGGLE_MODE != 0) ? (sync_out ^ req_last_q) : (sync_out & ~req_last_q);
      valid_d     = evt | (valid_q & ~bus.rd_pop);
      ovf_d       = (evt & valid_q & ~bus.rd_pop) | (ovf_q & ~bus.ovf_clr);
      any_valid_d = |valid_q;
      data_d      = data_q;
      for (int c = 0; c < NUM_CH; c++)
         data_d[c*DATA_WIDTH +: DATA_WIDTH] = evt[c] ? bus.wr_data[c*DATA_WIDTH +: DATA_WIDTH]
                                                     : data_q[c*DATA_WIDTH +: DATA_WIDTH];
   end
   always_ff @(posedge rd_clk or negedge rd_reset) begin
      if (!rd_reset) begin
         sync_q      <= '0;
         req_last_q  <= '0;
         valid_q     <= '0;
         ovf_q       <= '0;
         data_q      <= '0;
         any_valid_q <= 1'b0;
      end else begin
         sync_q      <= sync_d;
         req_last_q  <= req_last_d;
         valid_q     <= valid_d;
         ovf_q       <= ovf_d;
         data_q      <= data_d;
         any_valid_q <= any_valid_d;
      end
   end
   assign bus.rd_data      = data_q;
   assign bus.rd_valid     = valid_q;
   assign bus.rd_ack       = req_last_q;
   assign bus.rd_ovf       = ovf_q;
   assign bus.rd_any_valid = any_valid_q;
endmodule

// File: tb/tb_mux_sync_rx_multi.sv
// tb_mux_sync_rx_multi: directed checks of level and toggle receivers
module tb_mux_sync_rx_multi;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;
   always #5 clk = ~clk;
   mux_sync_rx_multi_if #(.NUM_CH(4), .DATA_WIDTH(12)) lv ();
   mux_sync_rx_multi_if #(.NUM_CH(4), .DATA_WIDTH(12)) tg ();
   mux_sync_rx_multi #(.NUM_CH(4), .DATA_WIDTH(12), .SYNC_STAGES(2), .TOGGLE_MODE(0)) u_lv (
      .rd_clk(clk), .rd_reset(rst_n), .bus(lv));
   mux_sync_rx_multi #(.NUM_CH(4), .DATA_WIDTH(12), .SYNC_STAGES(2), .TOGGLE_MODE(1)) u_tg (
      .rd_clk(clk), .rd_reset(rst_n), .bus(tg));

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic raise(input int c, input logic [11:0] v);
      lv.wr_data[c*12 +: 12] = v;
      lv.wr_req[c] = 1'b1;
      tick(3);
   endtask

   task automatic lower(input int c);
      lv.wr_req[c] = 1'b0;
      tick(4);
   endtask

   task automatic test_reset;
      lv.wr_req = 4'hF; lv.wr_data = {4{12'hABC}}; lv.rd_pop = '0; lv.ovf_clr = '0;
      tg.wr_req = '0;   tg.wr_data = '0;           tg.rd_pop = '0; tg.ovf_clr = '0;
      tick(3);
      n_cmp++; if (lv.rd_valid !== 4'h0) begin n_err++; $display("FAIL rst_valid got %h exp 0", lv.rd_valid); end
      n_cmp++; if (lv.rd_data !== 48'h0) begin n_err++; $display("FAIL rst_data got %h exp 0", lv.rd_data); end
      n_cmp++; if (lv.rd_ack !== 4'h0) begin n_err++; $display("FAIL rst_ack got %h exp 0", lv.rd_ack); end
      n_cmp++; if (lv.rd_ovf !== 4'h0) begin n_err++; $display("FAIL rst_ovf got %h exp 0", lv.rd_ovf); end
      n_cmp++; if (lv.rd_any_valid !== 1'b0) begin n_err++; $display("FAIL rst_any got %b exp 0", lv.rd_any_valid); end
      rst_n = 1'b1;
      tick(2);
      n_cmp++; if (lv.rd_valid !== 4'h0) begin n_err++; $display("FAIL rel_early got %h exp 0", lv.rd_valid); end
      tick(1);
      n_cmp++; if (lv.rd_valid !== 4'hF) begin n_err++; $display("FAIL rel_valid got %h exp f", lv.rd_valid); end
      n_cmp++; if (lv.rd_data !== {4{12'hABC}}) begin n_err++; $display("FAIL rel_data got %h exp abcabcabcabc", lv.rd_data); end
      n_cmp++; if (lv.rd_ack !== 4'hF) begin n_err++; $display("FAIL rel_ack got %h exp f", lv.rd_ack); end
      n_cmp++; if (tg.rd_valid !== 4'h0) begin n_err++; $display("FAIL rel_tg_valid got %h exp 0", tg.rd_valid); end
      tick(1);
      n_cmp++; if (lv.rd_any_valid !== 1'b1) begin n_err++; $display("FAIL rel_any got %b exp 1", lv.rd_any_valid); end
      lv.wr_req = 4'h0; lv.rd_pop = 4'hF;
      tick(1);
      lv.rd_pop = 4'h0;
      n_cmp++; if (lv.rd_valid !== 4'h0) begin n_err++; $display("FAIL pop_all got %h exp 0", lv.rd_valid); end
      n_cmp++; if (lv.rd_any_valid !== 1'b1) begin n_err++; $display("FAIL any_lag got %b exp 1", lv.rd_any_valid); end
      tick(1);
      n_cmp++; if (lv.rd_any_valid !== 1'b0) begin n_err++; $display("FAIL any_clr got %b exp 0", lv.rd_any_valid); end
      tick(3);
      n_cmp++; if (lv.rd_ack !== 4'h0) begin n_err++; $display("FAIL fall_ack got %h exp 0", lv.rd_ack); end
      n_cmp++; if (lv.rd_valid !== 4'h0) begin n_err++; $display("FAIL fall_nocap got %h exp 0", lv.rd_valid); end
   endtask

   task automatic test_level;
      lv.wr_data[12 +: 12] = 12'h5A5;
      lv.wr_req[1] = 1'b1;
      tick(2);
      n_cmp++; if (lv.rd_valid[1] !== 1'b0) begin n_err++; $display("FAIL lvl_early got %b exp 0", lv.rd_valid[1]); end
      tick(1);
      n_cmp++; if (lv.rd_valid[1] !== 1'b1) begin n_err++; $display("FAIL lvl_valid got %b exp 1", lv.rd_valid[1]); end
      n_cmp++; if (lv.rd_data[12 +: 12] !== 12'h5A5) begin n_err++; $display("FAIL lvl_data got %h exp 5a5", lv.rd_data[12 +: 12]); end
      n_cmp++; if (lv.rd_ack[1] !== 1'b1) begin n_err++; $display("FAIL lvl_ack got %b exp 1", lv.rd_ack[1]); end
      lv.rd_pop[1] = 1'b1;
      tick(1);
      lv.rd_pop[1] = 1'b0;
      n_cmp++; if (lv.rd_valid[1] !== 1'b0) begin n_err++; $display("FAIL lvl_pop got %b exp 0", lv.rd_valid[1]); end
      lv.wr_req[1] = 1'b0;
      tick(2);
      n_cmp++; if (lv.rd_ack[1] !== 1'b1) begin n_err++; $display("FAIL lvl_ack_hold got %b exp 1", lv.rd_ack[1]); end
      tick(1);
      n_cmp++; if (lv.rd_ack[1] !== 1'b0) begin n_err++; $display("FAIL lvl_ack_drop got %b exp 0", lv.rd_ack[1]); end
      n_cmp++; if (lv.rd_valid[1] !== 1'b0) begin n_err++; $display("FAIL lvl_fall_cap got %b exp 0", lv.rd_valid[1]); end
      n_cmp++; if (lv.rd_data[12 +: 12] !== 12'h5A5) begin n_err++; $display("FAIL lvl_data_hold got %h exp 5a5", lv.rd_data[12 +: 12]); end
      tick(2);
   endtask

   task automatic test_toggle;
      for (int k = 1; k <= 3; k++) begin
         logic [11:0] exp_d;
         exp_d = 12'(k);
         tg.wr_data[0 +: 12] = exp_d;
         tg.wr_req[0] = ~tg.wr_req[0];
         tick(3);
         n_cmp++; if (tg.rd_valid[0] !== 1'b1) begin n_err++; $display("FAIL tgl_valid%0d got %b exp 1", k, tg.rd_valid[0]); end
         n_cmp++; if (tg.rd_data[0 +: 12] !== exp_d) begin n_err++; $display("FAIL tgl_data%0d got %h exp %h", k, tg.rd_data[0 +: 12], exp_d); end
         n_cmp++; if (tg.rd_ack[0] !== exp_d[0]) begin n_err++; $display("FAIL tgl_ack%0d got %b exp %b", k, tg.rd_ack[0], exp_d[0]); end
         tg.rd_pop[0] = 1'b1;
         tick(1);
         tg.rd_pop[0] = 1'b0;
         n_cmp++; if (tg.rd_valid[0] !== 1'b0) begin n_err++; $display("FAIL tgl_pop%0d got %b exp 0", k, tg.rd_valid[0]); end
         tick(1);
      end
      n_cmp++; if (tg.rd_ack[0] !== 1'b1) begin n_err++; $display("FAIL tgl_ack_end got %b exp 1", tg.rd_ack[0]); end
      n_cmp++; if (tg.rd_ovf !== 4'h0) begin n_err++; $display("FAIL tgl_ovf got %h exp 0", tg.rd_ovf); end
   endtask

   task automatic test_overrun;
      raise(2, 12'h111);
      n_cmp++; if (lv.rd_ovf[2] !== 1'b0) begin n_err++; $display("FAIL ovf_first got %b exp 0", lv.rd_ovf[2]); end
      lower(2);
      raise(2, 12'h222);
      n_cmp++; if (lv.rd_data[24 +: 12] !== 12'h222) begin n_err++; $display("FAIL ovf_data got %h exp 222", lv.rd_data[24 +: 12]); end
      n_cmp++; if (lv.rd_ovf[2] !== 1'b1) begin n_err++; $display("FAIL ovf_set got %b exp 1", lv.rd_ovf[2]); end
      n_cmp++; if (lv.rd_valid[2] !== 1'b1) begin n_err++; $display("FAIL ovf_valid got %b exp 1", lv.rd_valid[2]); end
      lower(2);
      lv.wr_data[24 +: 12] = 12'h333;
      lv.wr_req[2] = 1'b1;
      tick(2);
      lv.ovf_clr[2] = 1'b1;
      tick(1);
      lv.ovf_clr[2] = 1'b0;
      n_cmp++; if (lv.rd_ovf[2] !== 1'b1) begin n_err++; $display("FAIL ovf_set_wins got %b exp 1", lv.rd_ovf[2]); end
      n_cmp++; if (lv.rd_data[24 +: 12] !== 12'h333) begin n_err++; $display("FAIL ovf_data3 got %h exp 333", lv.rd_data[24 +: 12]); end
      lower(2);
      lv.ovf_clr[2] = 1'b1;
      tick(1);
      lv.ovf_clr[2] = 1'b0;
      n_cmp++; if (lv.rd_ovf[2] !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %b exp 0", lv.rd_ovf[2]); end
      n_cmp++; if (lv.rd_valid[2] !== 1'b1) begin n_err++; $display("FAIL ovf_clr_valid got %b exp 1", lv.rd_valid[2]); end
      lv.rd_pop[2] = 1'b1;
      tick(1);
      lv.rd_pop[2] = 1'b0;
   endtask

   task automatic test_pop_collision;
      raise(3, 12'h666);
      n_cmp++; if (lv.rd_valid[3] !== 1'b1) begin n_err++; $display("FAIL col_pre got %b exp 1", lv.rd_valid[3]); end
      lower(3);
      lv.wr_data[36 +: 12] = 12'h777;
      lv.wr_req[3] = 1'b1;
      tick(2);
      lv.rd_pop[3] = 1'b1;
      tick(1);
      lv.rd_pop[3] = 1'b0;
      n_cmp++; if (lv.rd_valid[3] !== 1'b1) begin n_err++; $display("FAIL col_valid got %b exp 1", lv.rd_valid[3]); end
      n_cmp++; if (lv.rd_data[36 +: 12] !== 12'h777) begin n_err++; $display("FAIL col_data got %h exp 777", lv.rd_data[36 +: 12]); end
      n_cmp++; if (lv.rd_ovf[3] !== 1'b0) begin n_err++; $display("FAIL col_ovf got %b exp 0", lv.rd_ovf[3]); end
      lv.rd_pop[3] = 1'b1;
      tick(1);
      lv.rd_pop[3] = 1'b0;
      lower(3);
   endtask

   task automatic test_mid_reset;
      lv.ovf_clr = 4'h0;
      raise(2, 12'h123);
      n_cmp++; if (lv.rd_ovf[2] !== 1'b0) begin n_err++; $display("FAIL mr_ovf_pre got %b exp 0", lv.rd_ovf[2]); end
      lv.wr_data[0 +: 12] = 12'h999;
      lv.wr_req[0] = 1'b1;
      tick(2);
      rst_n = 1'b0;
      #1;
      n_cmp++; if (lv.rd_valid !== 4'h0) begin n_err++; $display("FAIL mr_valid got %h exp 0", lv.rd_valid); end
      n_cmp++; if (lv.rd_data !== 48'h0) begin n_err++; $display("FAIL mr_data got %h exp 0", lv.rd_data); end
      n_cmp++; if (lv.rd_ack !== 4'h0) begin n_err++; $display("FAIL mr_ack got %h exp 0", lv.rd_ack); end
      lv.wr_req = 4'h0;
      tg.wr_req = 4'h0;
      tick(2);
      rst_n = 1'b1;
      tick(5);
      n_cmp++; if (lv.rd_valid !== 4'h0) begin n_err++; $display("FAIL mr_post_valid got %h exp 0", lv.rd_valid); end
      n_cmp++; if (lv.rd_data !== 48'h0) begin n_err++; $display("FAIL mr_post_data got %h exp 0", lv.rd_data); end
      n_cmp++; if (lv.rd_any_valid !== 1'b0) begin n_err++; $display("FAIL mr_post_any got %b exp 0", lv.rd_any_valid); end
      n_cmp++; if (tg.rd_valid !== 4'h0) begin n_err++; $display("FAIL mr_post_tg got %h exp 0", tg.rd_valid); end
      raise(0, 12'hAAA);
      n_cmp++; if (lv.rd_valid !== 4'h1) begin n_err++; $display("FAIL mr_fresh_valid got %h exp 1", lv.rd_valid); end
      n_cmp++; if (lv.rd_data[0 +: 12] !== 12'hAAA) begin n_err++; $display("FAIL mr_fresh_data got %h exp aaa", lv.rd_data[0 +: 12]); end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_level();
      test_toggle();
      test_overrun();
      test_pop_collision();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
